// File: rtl/fpnew_f2fcast_simd.sv
// Packed-SIMD float-to-float cast with an elastic output pipeline.
// Each lane converts independently; flags of enabled lanes are merged.

package fpnew_f2fcast_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd8;
            FP64:    return 32'd11;
            FP16:    return 32'd5;
            FP8:     return 32'd5;
            FP16ALT: return 32'd8;
            default: return 32'd8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd23;
            FP64:    return 32'd52;
            FP16:    return 32'd10;
            FP8:     return 32'd2;
            FP16ALT: return 32'd7;
            default: return 32'd23;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return 32'd1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

module fpnew_f2fcast_simd #(
    parameter fpnew_f2fcast_pkg::fp_format_e SrcFpFormat = fpnew_f2fcast_pkg::FP32,
    parameter fpnew_f2fcast_pkg::fp_format_e DstFpFormat = fpnew_f2fcast_pkg::FP16,
    parameter int unsigned NumLanes    = 2,
    parameter int unsigned NumPipeRegs = 2,
    parameter type         TagType     = logic,
    localparam int unsigned SW = fpnew_f2fcast_pkg::fp_width(SrcFpFormat),
    localparam int unsigned DW = fpnew_f2fcast_pkg::fp_width(DstFpFormat)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumLanes*SW-1:0] operands_i,
    input  logic [NumLanes-1:0]    is_boxed_i,
    input  logic [NumLanes-1:0]    lane_mask_i,
    input  logic [2:0]             rnd_mode_i,
    input  TagType                 tag_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   flush_i,
    output logic [NumLanes*DW-1:0] result_o,
    output logic [4:0]             status_o,
    output TagType                 tag_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   busy_o
);

    localparam int unsigned SE = fpnew_f2fcast_pkg::exp_bits(SrcFpFormat);
    localparam int unsigned SM = fpnew_f2fcast_pkg::man_bits(SrcFpFormat);
    localparam int unsigned DE = fpnew_f2fcast_pkg::exp_bits(DstFpFormat);
    localparam int unsigned DM = fpnew_f2fcast_pkg::man_bits(DstFpFormat);
    localparam int SBIAS = (2 ** (SE - 1)) - 1;
    localparam int DBIAS = (2 ** (DE - 1)) - 1;
    localparam int EMAX  = (2 ** DE) - 1;
    // Working mantissa: hidden bit + widest fraction + guard room for round/sticky.
    localparam int P     = DM + SM + 4;

    // Converts one lane; returns {NV,DZ,OF,UF,NX, result}.
    function automatic logic [DW+4:0] cast_lane(
        input logic [SW-1:0] op,
        input logic          boxed,
        input logic [2:0]    rm
    );
        logic           sgn;
        logic [SE-1:0]  ex;
        logic [SM-1:0]  fr;
        logic [SM-1:0]  fr_n;
        int unsigned    lz;
        logic           found;
        int             dexp;
        int             shamt;
        logic [P-1:0]   m;
        logic [P-1:0]   sh;
        logic           lost;
        logic [DM:0]    kept;
        logic           rb;
        logic           sb;
        logic           inc;
        logic           to_inf;
        logic [DE-1:0]  ebase;
        logic [DE+DM-1:0] pre;
        logic [DE+DM-1:0] rnd;
        logic           nv;
        logic           of;
        logic           uf;
        logic           nx;
        logic [DW-1:0]  res;

        sgn   = op[SW-1];
        ex    = op[SW-2 -: SE];
        fr    = op[SM-1:0];
        fr_n  = fr;
        lz    = 32'd0;
        found = 1'b0;
        dexp  = 32'sd0;
        shamt = 32'sd0;
        m     = '0;
        sh    = '0;
        lost  = 1'b0;
        kept  = '0;
        rb    = 1'b0;
        sb    = 1'b0;
        inc   = 1'b0;
        ebase = '0;
        pre   = '0;
        rnd   = '0;
        nv    = 1'b0;
        of    = 1'b0;
        uf    = 1'b0;
        nx    = 1'b0;
        res   = '0;
        to_inf = (rm == 3'd0) | (rm == 3'd4) | ((rm == 3'd3) & ~sgn) | ((rm == 3'd2) & sgn);

        // Leading-zero count of the fraction, used to renormalise subnormals.
        for (int i = int'(SM) - 1; i >= 0; i--) begin
            if (found) lz = lz;
            else if (fr[i]) found = 1'b1;
            else lz = lz + 32'd1;
        end

        if (!boxed) begin
            res = {1'b0, {DE{1'b1}}, 1'b1, {(DM-1){1'b0}}};
        end else if (ex == '1) begin
            if (fr == '0) begin
                res = {sgn, {DE{1'b1}}, {DM{1'b0}}};
            end else begin
                res = {1'b0, {DE{1'b1}}, 1'b1, {(DM-1){1'b0}}};
                nv  = ~fr[SM-1];
            end
        end else if ((ex == '0) && (fr == '0)) begin
            res = {sgn, {(DW-1){1'b0}}};
        end else begin
            if (ex == '0) begin
                fr_n = fr << (lz + 32'd1);
                dexp = DBIAS - SBIAS - int'(lz);
            end else begin
                fr_n = fr;
                dexp = int'(ex) - SBIAS + DBIAS;
            end
            m = {1'b1, fr_n, {(P-SM-1){1'b0}}};
            // Tiny results shift right into the subnormal range; lost bits go to sticky.
            if (dexp >= 32'sd1) shamt = 32'sd0;
            else if ((32'sd1 - dexp) >= P) shamt = P;
            else shamt = 32'sd1 - dexp;
            sh   = m >> shamt;
            lost = |(m << (P - shamt));
            kept = sh[P-1 -: DM+1];
            rb   = sh[P-DM-2];
            sb   = (|sh[P-DM-3:0]) | lost;
            if (dexp >= EMAX) begin
                of = 1'b1;
            end else begin
                // Hidden bit in kept lifts ebase back to the true exponent.
                if (dexp >= 32'sd1) ebase = DE'(dexp - 32'sd1);
                else ebase = '0;
                pre = {ebase, {DM{1'b0}}} + (DE+DM)'(kept);
                case (rm)
                    3'd0:    inc = rb & (sb | kept[0]);
                    3'd1:    inc = 1'b0;
                    3'd2:    inc = (rb | sb) & sgn;
                    3'd3:    inc = (rb | sb) & ~sgn;
                    3'd4:    inc = rb;
                    default: inc = 1'b0;
                endcase
                rnd = pre + (DE+DM)'(inc);
                of  = (rnd[DE+DM-1 -: DE] == '1);
            end
            nx = rb | sb | of;
            if (of) begin
                if (to_inf) res = {sgn, {DE{1'b1}}, {DM{1'b0}}};
                else res = {sgn, {(DE-1){1'b1}}, 1'b0, {DM{1'b1}}};
            end else begin
                res = {sgn, rnd};
                uf  = (rnd[DE+DM-1 -: DE] == '0) & nx;
            end
        end
        return {nv, 1'b0, of, uf, nx, res};
    endfunction

    logic [NumLanes*DW-1:0] result_s;
    logic [4:0]             status_s;
    logic [DW+4:0]          lane_out_s;

    // Per-lane conversion; masked lanes are zeroed and raise no flags.
    always_comb begin
        result_s   = '0;
        status_s   = '0;
        lane_out_s = '0;
        for (int l = 0; l < int'(NumLanes); l++) begin
            lane_out_s = cast_lane(operands_i[l*SW +: SW], is_boxed_i[l], rnd_mode_i);
            if (lane_mask_i[l]) begin
                result_s[l*DW +: DW] = lane_out_s[DW-1:0];
                status_s = status_s | lane_out_s[DW+4:DW];
            end else begin
                result_s[l*DW +: DW] = '0;
            end
        end
    end

    if (NumPipeRegs == 0) begin : g_comb
        assign in_ready_o  = out_ready_i;
        assign out_valid_o = in_valid_i;
        assign result_o    = result_s;
        assign status_o    = status_s;
        assign tag_o       = tag_i;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        logic [NumPipeRegs-1:0]  valid_r;
        logic [NumPipeRegs-1:0]  accept_s;
        logic [NumPipeRegs-1:0]  up_valid_s;
        logic                    full_tail_s;
        logic [NumLanes*DW-1:0]  data_r      [NumPipeRegs];
        logic [4:0]              status_r    [NumPipeRegs];
        TagType                  tag_r       [NumPipeRegs];
        logic [NumLanes*DW-1:0]  up_data_s   [NumPipeRegs];
        logic [4:0]              up_status_s [NumPipeRegs];
        TagType                  up_tag_s    [NumPipeRegs];

        // A stage accepts unless it and every later stage are full and the sink stalls.
        always_comb begin
            accept_s    = '0;
            full_tail_s = 1'b1;
            for (int k = 0; k < int'(NumPipeRegs); k++) begin
                full_tail_s = 1'b1;
                for (int j = k; j < int'(NumPipeRegs); j++) begin
                    full_tail_s = full_tail_s & valid_r[j];
                end
                accept_s[k] = out_ready_i | ~full_tail_s;
            end
        end

        // Upstream view of each stage: cast datapath feeds stage 0.
        always_comb begin
            up_valid_s     = '0;
            up_valid_s[0]  = in_valid_i;
            up_data_s[0]   = result_s;
            up_status_s[0] = status_s;
            up_tag_s[0]    = tag_i;
            for (int k = 1; k < int'(NumPipeRegs); k++) begin
                up_valid_s[k]  = valid_r[k-1];
                up_data_s[k]   = data_r[k-1];
                up_status_s[k] = status_r[k-1];
                up_tag_s[k]    = tag_r[k-1];
            end
        end

        // Valid bits: cleared by reset or flush, otherwise advance on accept.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_r <= '0;
            end else if (flush_i) begin
                valid_r <= '0;
            end else begin
                for (int k = 0; k < int'(NumPipeRegs); k++) begin
                    if (accept_s[k]) valid_r[k] <= up_valid_s[k];
                end
            end
        end

        // Payload registers move with their valid bit and need no reset.
        always_ff @(posedge clk_i) begin
            for (int k = 0; k < int'(NumPipeRegs); k++) begin
                if (accept_s[k]) begin
                    data_r[k]   <= up_data_s[k];
                    status_r[k] <= up_status_s[k];
                    tag_r[k]    <= up_tag_s[k];
                end
            end
        end

        assign in_ready_o  = accept_s[0];
        assign out_valid_o = valid_r[NumPipeRegs-1];
        assign result_o    = data_r[NumPipeRegs-1];
        assign status_o    = status_r[NumPipeRegs-1];
        assign tag_o       = tag_r[NumPipeRegs-1];
        assign busy_o      = |valid_r;
    end

endmodule

// File: tb/tb_fpnew_f2fcast_simd.sv
// Bench for fpnew_f2fcast_simd: FP32->FP16, two lanes, two pipe stages.
// Expected values come from a value-based rounding model and directed constants.

module tb_fpnew_f2fcast_simd;

    logic        clk;
    logic        rst_n;
    logic [63:0] operands;
    logic [1:0]  boxed;
    logic [1:0]  mask;
    logic [2:0]  rm;
    logic [7:0]  tag;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] result;
    logic [4:0]  status;
    logic [7:0]  tag_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    fpnew_f2fcast_simd #(
        .NumLanes    (2),
        .NumPipeRegs (2),
        .TagType     (logic [7:0])
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .operands_i  (operands),
        .is_boxed_i  (boxed),
        .lane_mask_i (mask),
        .rnd_mode_i  (rm),
        .tag_i       (tag),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .flush_i     (flush),
        .result_o    (result),
        .status_o    (status),
        .tag_o       (tag_out),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  st;
        logic [7:0]  tg;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_lat = 0;
    int          nout = 0;
    logic        use_const = 1'b0;
    logic [31:0] c_res = 32'd0;
    logic [4:0]  c_st = 5'd0;
    logic        hold_pend = 1'b0;
    logic [44:0] hold_word = 45'd0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // Exact value model: value = m * 2^ee, quantised to the FP16 grid 2^q.
    function automatic logic [20:0] ref_lane(input logic [31:0] x, input logic bx, input logic [2:0] r_m);
        logic   s;
        int     e8, ee, q, msb, shv, expf;
        longint m, n, rem, half;
        bit     gt, eq, inx, inc, big;
        s  = x[31];
        e8 = int'(x[30:23]);
        m  = longint'(x[22:0]);
        if (!bx) return {5'd0, 16'h7E00};
        if (e8 == 255) begin
            if (m == 0) return {5'd0, s, 15'h7C00};
            return {(x[22] ? 5'd0 : 5'b10000), 16'h7E00};
        end
        if (e8 == 0 && m == 0) return {5'd0, s, 15'd0};
        if (e8 == 0) ee = -149;
        else begin
            m  = m + 64'd8388608;
            ee = e8 - 150;
        end
        msb = -1;
        for (int i = 0; i < 24; i++) if (m[i]) msb = i;
        q = msb + ee - 10;
        if (q < -24) q = -24;
        shv = q - ee;
        gt = 0; eq = 0; inx = 0;
        if (shv <= 0) n = m <<< (-shv);
        else if (shv >= 40) begin n = 0; inx = 1; end
        else begin
            n    = m >> shv;
            rem  = m - (n << shv);
            half = 64'd1 << (shv - 1);
            inx  = (rem != 0);
            gt   = (rem > half);
            eq   = (rem == half);
        end
        case (r_m)
            3'd0:    inc = gt || (eq && n[0]);
            3'd2:    inc = s && inx;
            3'd3:    inc = !s && inx;
            3'd4:    inc = gt || eq;
            default: inc = 0;
        endcase
        if (inc) n = n + 1;
        if (n == 2048) begin n = 1024; q++; end
        expf = (n >= 1024) ? q + 25 : 0;
        if (expf >= 31) begin
            big = (r_m == 3'd0) || (r_m == 3'd4) || (r_m == 3'd3 && !s) || (r_m == 3'd2 && s);
            return {5'b00101, s, (big ? 15'h7C00 : 15'h7BFF)};
        end
        return {3'b000, (expf == 0 && inx), inx, s, 5'(expf), n[9:0]};
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        int c;
        v = $urandom;
        c = $urandom_range(0, 10);
        case (c)
            1, 2, 3, 4, 5, 6: v[30:23] = 8'($urandom_range(96, 150));
            7: begin
                v[30:23] = 8'd0;
                if ($urandom_range(0, 3) == 0) v[22:0] = 23'd0;
            end
            8: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
            end
            9:  v[30:23] = 8'($urandom_range(140, 143));
            10: v[12:0] = 13'h1000;
            default: v = v;
        endcase
        return v;
    endfunction

    // One clock: score outputs/inputs at the falling edge, then pass the rising edge.
    task automatic tick();
        exp_t        e;
        logic [20:0] r;
        @(negedge clk);
        if (hold_pend) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({result, status, tag_out}), 64'(hold_word));
        end
        hold_pend = out_valid && !out_ready && !flush && rst_n;
        hold_word = {result, status, tag_out};
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("status", 64'(status), 64'(e.st));
                check("tag", 64'(tag_out), 64'(e.tg));
                last_lat = cyc - e.cyc;
                nout++;
            end
        end
        if (in_valid && in_ready && !flush && rst_n) begin
            if (use_const) begin
                e.res = c_res;
                e.st  = c_st;
            end else begin
                e.res = 32'd0;
                e.st  = 5'd0;
                for (int l = 0; l < 2; l++) begin
                    if (mask[l]) begin
                        r = ref_lane(operands[l*32 +: 32], boxed[l], rm);
                        e.res[l*16 +: 16] = r[15:0];
                        e.st = e.st | r[20:16];
                    end
                end
            end
            e.tg  = tag;
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        if (flush) sb.delete();
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic send_const(input logic [63:0] ops, input logic [1:0] bx, input logic [1:0] mk,
                              input logic [2:0] r_m, input logic [31:0] eres, input logic [4:0] est);
        operands  = ops;
        boxed     = bx;
        mask      = mk;
        rm        = r_m;
        tag       = tag + 8'd1;
        use_const = 1'b1;
        c_res     = eres;
        c_st      = est;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("directed_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        use_const = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        int k;
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        operands = 64'd0; boxed = 2'b11; mask = 2'b11; rm = 3'd0; tag = 8'd0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Exact conversion, first edge after reset, latency 2
        send_const({32'hC000_0000, 32'h3F80_0000}, 2'b11, 2'b11, 3'd0, {16'hC000, 16'h3C00}, 5'd0);
        check("latency", 64'(last_lat), 64'd2);

        // Overflow per rounding mode
        send_const({32'h3F80_0000, 32'h7F7F_FFFF}, 2'b11, 2'b11, 3'd0, {16'h3C00, 16'h7C00}, 5'b00101);
        send_const({32'h3F80_0000, 32'h7F7F_FFFF}, 2'b11, 2'b11, 3'd1, {16'h3C00, 16'h7BFF}, 5'b00101);
        send_const({32'h0000_0000, 32'hFF7F_FFFF}, 2'b11, 2'b11, 3'd2, {16'h0000, 16'hFC00}, 5'b00101);
        send_const({32'h0000_0000, 32'hFF7F_FFFF}, 2'b11, 2'b11, 3'd3, {16'h0000, 16'hFBFF}, 5'b00101);

        // Specials: sNaN, deep underflow, unboxed lane
        send_const({32'h0DA2_4260, 32'h7F80_0001}, 2'b11, 2'b11, 3'd0, {16'h0000, 16'h7E00}, 5'b10011);
        send_const({32'h3F80_0000, 32'h3F80_0000}, 2'b01, 2'b11, 3'd0, {16'h7E00, 16'h3C00}, 5'd0);

        // Lane mask hides a sNaN
        send_const({32'h7F80_0001, 32'h4040_0000}, 2'b11, 2'b01, 3'd0, {16'h0000, 16'h4200}, 5'd0);

        // Ties and subnormal boundary
        send_const({32'h3F80_3000, 32'h3F80_1000}, 2'b11, 2'b11, 3'd0, {16'h3C02, 16'h3C00}, 5'b00001);
        send_const({32'h3F80_3000, 32'h3F80_1000}, 2'b11, 2'b11, 3'd4, {16'h3C02, 16'h3C01}, 5'b00001);
        send_const({32'h3300_0000, 32'h3380_0000}, 2'b11, 2'b11, 3'd0, {16'h0000, 16'h0001}, 5'b00011);
        send_const({32'h3300_0000, 32'h3380_0000}, 2'b11, 2'b11, 3'd3, {16'h0001, 16'h0001}, 5'b00011);

        // Backpressure: six back-to-back inputs, sink stalled for four cycles
        n0 = nout; k = 0;
        operands = {rand_val(), rand_val()}; boxed = 2'b11; mask = 2'b11; rm = 3'd0;
        for (int t = 0; t < 40 && (k < 6 || sb.size() > 0); t++) begin
            out_ready = !(t >= 2 && t < 6);
            in_valid  = (k < 6);
            tag       = 8'h40 + 8'(k);
            if (t == 4) check("full_in_ready", 64'(in_ready), 64'd0);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                k++;
                operands = {rand_val(), rand_val()};
            end
        end
        in_valid = 1'b0;
        check("bp_count", 64'(nout - n0), 64'd6);

        // Random traffic with random backpressure
        for (int t = 0; t < 300; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            operands  = {rand_val(), rand_val()};
            boxed     = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
            mask      = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            rm        = 3'($urandom_range(0, 4));
            tag       = 8'($urandom);
            tick();
        end
        drain();

        // Flush with two results in flight plus a same-cycle input
        out_ready = 1'b0; in_valid = 1'b1; rm = 3'd0; mask = 2'b11; boxed = 2'b11;
        for (int t = 0; t < 2; t++) begin
            operands = {rand_val(), rand_val()};
            tag = 8'h80 + 8'(t);
            tick();
        end
        check("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1; out_ready = 1'b1; tag = 8'h90;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        for (int t = 0; t < 4; t++) begin
            tick();
            check("flush_no_stale", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 2; t++) begin
            operands = {rand_val(), rand_val()};
            tag = 8'hA0 + 8'(t);
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        hold_pend = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("arst_no_stale", 64'(out_valid), 64'd0);
        end

        // Traffic resumes normally after reset
        for (int t = 0; t < 40; t++) begin
            in_valid  = 1'b1;
            out_ready = ($urandom_range(0, 2) != 0);
            operands  = {rand_val(), rand_val()};
            rm        = 3'($urandom_range(0, 4));
            tag       = 8'($urandom);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
